// File: rtl/fadc_rd_pkg.sv
// Shared types and defaults for the FADC buffer read engine.
package fadc_rd_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_t;

  typedef logic [ADDR_W_DEF:0] count_t;

endpackage

// File: rtl/fadc_rd_fifo.sv
// Small synchronous skid FIFO; occupancy feeds the read-issue credit check.
module fadc_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fadc_buffer_reader.sv
// Fetches a wrap-around block from the FADC buffer read port and streams it out
// over valid/ready, hiding RAM latency behind a credit-limited skid FIFO.
module fadc_buffer_reader
  import fadc_rd_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = RD_LAT + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   n_words,
  input  logic              abort,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   CntW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned   SumW     = 8;
  localparam logic [ADDR_W:0] CountOne = (ADDR_W + 1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remain;
  // tok[0] marks a cycle in which rdaddress carries a fresh address; q is
  // valid for it when the token reaches tok[RD_LAT].
  logic [RD_LAT:0]   tok;
  logic [CntW-1:0]   occ;
  logic              fifo_empty;
  logic              pop;
  logic              start_ok;
  logic              issue;
  logic              drain_ok;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W:0]   issue_rem;
  logic [SumW-1:0]   pending;

  always_comb begin
    pending = SumW'(occ);
    for (int i = 0; i <= RD_LAT; i++) pending = pending + SumW'(tok[i]);
  end

  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign start_ok   = (state == StIdle) && start && (n_words != '0);
  assign issue_addr = start_ok ? start_addr : addr;
  assign issue_rem  = start_ok ? n_words : remain;
  // A pop in the same cycle frees the slot the new token will eventually need.
  assign issue      = start_ok ||
                      ((state == StRead) && (pending < SumW'(FIFO_DEPTH) + SumW'(pop)));
  assign drain_ok   = (tok == '0) && ((occ == '0) || ((occ == CntW'(1)) && pop));

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state     <= StIdle;
      rdaddress <= '0;
      addr      <= '0;
      remain    <= '0;
      tok       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      tok  <= {tok[RD_LAT-1:0], issue};
      if (issue) begin
        rdaddress <= issue_addr;
        addr      <= issue_addr + 1'b1;
        remain    <= issue_rem - 1'b1;
        busy      <= 1'b1;
        state     <= (issue_rem == CountOne) ? StDrain : StRead;
      end else begin
        case (state)
          StIdle:  if (start && (n_words == '0)) done <= 1'b1;
          StDrain: begin
            if (drain_ok) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fadc_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CntW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (abort),
    .push      (tok[RD_LAT]),
    .push_data (q),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (occ)
  );

endmodule
